// File: rtl/jtframe_mist_spi_rx_if.sv
// ioctl download bus between the MiST SPI receiver and the game loader.
//   ioctl_index  : file index announced by the last index command
//   ioctl_addr   : byte address of the current/last write
//   ioctl_dout   : byte being written
//   ioctl_wr     : one-clk write strobe
//   downloading  : high for the duration of a transfer
// master = receiver (drives the bus), slave = loader (consumes it).
interface jtframe_mist_spi_rx_if #(
    parameter int AW = 25
);
    logic [7:0]    ioctl_index;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wr;
    logic          downloading;

    modport master (
        output ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr, downloading
    );

    modport slave (
        input ioctl_index, ioctl_addr, ioctl_dout, ioctl_wr, downloading
    );
endinterface

// File: rtl/jtframe_mist_spi_rx.sv
// SPI responder for the MiST ARM ROM download channel (SS2). Oversamples the
// SPI pins, assembles bytes and decodes the file-transfer command stream onto
// the ioctl write bus.
//   clk, rst_n      : system clock / async active-low reset (clk >= 4x SCK)
//   SPI_SCK/SS2/DI  : SPI mode 0 inputs, MSB first, SS2 active low
//   SPI_DO          : MISO, driven low while SS2 is low, else released
//   ioctl           : download bus (master side)
module jtframe_mist_spi_rx #(
    parameter int AW   = 25,
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SPI_SCK,
    input  logic SPI_SS2,
    input  logic SPI_DI,
    output wire  SPI_DO,
    jtframe_mist_spi_rx_if.master ioctl
);
    typedef enum logic [2:0] {IDLE, CMD, PARAM_TX, PARAM_IDX, DATA, IGNORE} state_t;

    localparam logic [7:0] CMD_TX   = 8'h53;
    localparam logic [7:0] CMD_DATA = 8'h54;
    localparam logic [7:0] CMD_IDX  = 8'h55;

    state_t state, state_nx;

    logic [SYNC-1:0] sck_s, ss2_s, di_s;
    logic            sck_q, rise_q, di_q, ss2_q, ss2_qq;
    logic [2:0]      bit_cnt;
    logic [6:0]      shift;
    logic [7:0]      rx_byte;
    logic            byte_valid;
    logic [SYNC+1:0] settle;
    logic            armed;
    logic            ss2_rise, ss2_fall;
    logic            do_wr, set_dl, clr_dl, set_idx;

    assign SPI_DO = SPI_SS2 ? 1'bz : 1'b0;

    // Synchronisers plus one alignment stage: rise_q, di_q and ss2_q all
    // describe the same sampled instant.
    // NOTE: every clocked process uses non-blocking assignments so that all
    // flops see the pre-edge values of each other, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_s  <= '0;
            ss2_s  <= '1;
            di_s   <= '0;
            sck_q  <= 1'b0;
            rise_q <= 1'b0;
            di_q   <= 1'b0;
            ss2_q  <= 1'b1;
            ss2_qq <= 1'b1;
        end else begin
            sck_s  <= {sck_s[SYNC-2:0], SPI_SCK};
            ss2_s  <= {ss2_s[SYNC-2:0], SPI_SS2};
            di_s   <= {di_s[SYNC-2:0], SPI_DI};
            sck_q  <= sck_s[SYNC-1];
            rise_q <= sck_s[SYNC-1] & ~sck_q;
            di_q   <= di_s[SYNC-1];
            ss2_q  <= ss2_s[SYNC-1];
            ss2_qq <= ss2_q;
        end
    end

    assign ss2_rise = ss2_q & ~ss2_qq;
    assign ss2_fall = ~ss2_q & ss2_qq;

    // The SS2 chain comes out of reset holding "high", which would look like a
    // frame start if the pin is actually low. Only accept a frame start once a
    // genuinely sampled high level has been seen, so a frame interrupted by
    // reset is ignored until SS2 goes high and falls again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[SYNC:0], 1'b1};
            armed  <= armed | (settle[SYNC+1] & ss2_q);
        end
    end

    // Byte assembly; SS2 high discards any partial byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= rise_q & ~ss2_q & (bit_cnt == 3'd7);
            if (ss2_q) begin
                bit_cnt <= '0;
            end else if (rise_q) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {shift[5:0], di_q};
                if (bit_cnt == 3'd7) rx_byte <= {shift, di_q};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        do_wr    = 1'b0;
        set_dl   = 1'b0;
        clr_dl   = 1'b0;
        set_idx  = 1'b0;
        if (ss2_rise) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (ss2_fall && armed) state_nx = CMD;
                CMD: if (byte_valid) begin
                    case (rx_byte)
                        CMD_TX:   state_nx = PARAM_TX;
                        CMD_DATA: state_nx = DATA;
                        CMD_IDX:  state_nx = PARAM_IDX;
                        default:  state_nx = IGNORE;
                    endcase
                end
                PARAM_TX: if (byte_valid) begin
                    set_dl   = (rx_byte == 8'hff);
                    clr_dl   = (rx_byte == 8'h00);
                    state_nx = IGNORE;
                end
                PARAM_IDX: if (byte_valid) begin
                    set_idx  = 1'b1;
                    state_nx = IGNORE;
                end
                DATA:    do_wr = byte_valid & ioctl.downloading;
                IGNORE:  state_nx = IGNORE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // The address advances on the clk after the strobe, so it still names the
    // written byte while ioctl_wr is high; after the last write it equals the
    // transfer length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ioctl.ioctl_index <= '0;
            ioctl.ioctl_addr  <= '0;
            ioctl.ioctl_dout  <= '0;
            ioctl.ioctl_wr    <= 1'b0;
            ioctl.downloading <= 1'b0;
        end else begin
            ioctl.ioctl_wr <= do_wr;
            if (do_wr)   ioctl.ioctl_dout  <= rx_byte;
            if (set_idx) ioctl.ioctl_index <= rx_byte;
            if (set_dl)  ioctl.downloading <= 1'b1;
            else if (clr_dl) ioctl.downloading <= 1'b0;
            if (set_dl)              ioctl.ioctl_addr <= '0;
            else if (ioctl.ioctl_wr) ioctl.ioctl_addr <= ioctl.ioctl_addr + AW'(1);
        end
    end
endmodule

// File: tb/tb_jtframe_mist_spi_rx.sv
module tb_jtframe_mist_spi_rx;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic sck, ss2, di;
    wire  spi_do, spi_do4;
    int   cyc = 0;
    int   last_rise_cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jtframe_mist_spi_rx_if #(.AW(25)) bus ();
    jtframe_mist_spi_rx_if #(.AW(4))  bus4 ();

    jtframe_mist_spi_rx #(.AW(25), .SYNC(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
        .SPI_DO(spi_do), .ioctl(bus)
    );

    jtframe_mist_spi_rx #(.AW(4), .SYNC(SYNC)) dut4 (
        .clk(clk), .rst_n(rst_n), .SPI_SCK(sck), .SPI_SS2(ss2), .SPI_DI(di),
        .SPI_DO(spi_do4), .ioctl(bus4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        int unsigned addr;
        logic [7:0]  data;
    } wr_t;

    wr_t wq[$];
    wr_t wq4[$];
    int  lat_q[$];
    logic        wr_prev = 1'b0;
    logic [24:0] prev_addr = '0;

    // Write monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus.ioctl_wr) begin
            wq.push_back('{int'(bus.ioctl_addr), bus.ioctl_dout});
            lat_q.push_back(cyc - last_rise_cyc);
            check("wr_single_clk", {31'b0, wr_prev}, 32'd0);
        end
        if (wr_prev && !bus.ioctl_wr)
            check("addr_post_inc", bus.ioctl_addr, 32'(prev_addr + 25'd1));
        if (bus4.ioctl_wr) wq4.push_back('{int'(bus4.ioctl_addr), bus4.ioctl_dout});
        wr_prev   <= bus.ioctl_wr;
        prev_addr <= bus.ioctl_addr;
    end

    // Drive n bits of v, MSB first; caller is at a falling clk edge.
    task automatic spi_bits(input logic [7:0] v, input int n, input int half);
        for (int i = 7; i > 7 - n; i--) begin
            sck = 1'b0;
            di  = v[i];
            repeat (half) @(negedge clk);
            sck = 1'b1;
            last_rise_cyc = cyc + 1;
            repeat (half) @(negedge clk);
        end
        sck = 1'b0;
    endtask

    task automatic frame_begin();
        ss2 = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (8) @(negedge clk);
        ss2 = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame2(input logic [7:0] a, input logic [7:0] b, input int half);
        frame_begin();
        spi_bits(a, 8, half);
        spi_bits(b, 8, half);
        frame_end();
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] param;
        logic [7:0] exp_idx;
        logic       exp_dl;
    } vec_t;

    vec_t tbl[8];
    int   errs;

    initial begin
        tbl[0] = '{8'h55, 8'h03, 8'h03, 1'b0};
        tbl[1] = '{8'h53, 8'h42, 8'h03, 1'b0};
        tbl[2] = '{8'h55, 8'ha7, 8'ha7, 1'b0};
        tbl[3] = '{8'h53, 8'hff, 8'ha7, 1'b1};
        tbl[4] = '{8'h99, 8'h55, 8'ha7, 1'b1};
        tbl[5] = '{8'h53, 8'hff, 8'ha7, 1'b1};
        tbl[6] = '{8'h53, 8'h00, 8'ha7, 1'b0};
        tbl[7] = '{8'h55, 8'h03, 8'h03, 1'b0};

        rst_n = 1'b0;
        ss2   = 1'b0;
        sck   = 1'b0;
        di    = 1'b0;
        @(negedge clk);

        // Reset held with SS2 low and SCK toggling.
        spi_bits(8'h54, 8, 2);
        spi_bits(8'h53, 8, 2);
        check("rst_index", bus.ioctl_index, 32'd0);
        check("rst_addr", bus.ioctl_addr, 32'd0);
        check("rst_dout", bus.ioctl_dout, 32'd0);
        check("rst_wr", {31'b0, bus.ioctl_wr}, 32'd0);
        check("rst_dl", {31'b0, bus.downloading}, 32'd0);
        check("rst_spi_do", {31'b0, spi_do}, 32'd0);
        // Release mid-frame: rest of this frame must be ignored.
        rst_n = 1'b1;
        spi_bits(8'h55, 8, 2);
        spi_bits(8'h09, 8, 2);
        spi_bits(8'h53, 8, 2);
        spi_bits(8'hff, 8, 2);
        frame_end();
        check("postrst_index", bus.ioctl_index, 32'd0);
        check("postrst_dl", {31'b0, bus.downloading}, 32'd0);
        check("postrst_nowr", wq.size(), 32'd0);

        // Data before any transfer start is dropped.
        frame_begin();
        spi_bits(8'h54, 8, 2);
        spi_bits(8'h12, 8, 2);
        spi_bits(8'h34, 8, 2);
        frame_end();
        check("drop_nowr", wq.size(), 32'd0);

        // Control-frame table.
        foreach (tbl[i]) begin
            frame2(tbl[i].cmd, tbl[i].param, 2);
            check("tbl_index", bus.ioctl_index, {24'b0, tbl[i].exp_idx});
            check("tbl_dl", {31'b0, bus.downloading}, {31'b0, tbl[i].exp_dl});
            check("tbl_addr", bus.ioctl_addr, 32'd0);
            check("tbl_nowr", wq.size(), 32'd0);
        end

        // Basic transfer with a slow SCK, also checking strobe latency.
        wq.delete();
        lat_q.delete();
        frame2(8'h53, 8'hff, 8);
        check("basic_dl_on", {31'b0, bus.downloading}, 32'd1);
        frame_begin();
        spi_bits(8'h54, 8, 8);
        spi_bits(8'ha5, 8, 8);
        spi_bits(8'h5a, 8, 8);
        spi_bits(8'h11, 8, 8);
        frame_end();
        check("basic_count", wq.size(), 32'd3);
        if (wq.size() == 3) begin
            check("basic_a0", wq[0].addr, 32'd0);
            check("basic_d0", wq[0].data, 32'ha5);
            check("basic_a1", wq[1].addr, 32'd1);
            check("basic_d1", wq[1].data, 32'h5a);
            check("basic_a2", wq[2].addr, 32'd2);
            check("basic_d2", wq[2].data, 32'h11);
            check("basic_latency", lat_q[0], SYNC + 2);
        end
        check("basic_dout_hold", bus.ioctl_dout, 32'h11);
        frame2(8'h53, 8'h00, 8);
        check("basic_dl_off", {31'b0, bus.downloading}, 32'd0);
        check("basic_len", bus.ioctl_addr, 32'd3);

        // Second start while downloading restarts the address.
        wq.delete();
        frame2(8'h53, 8'hff, 2);
        frame2(8'h54, 8'h77, 2);
        check("restart_pre", bus.ioctl_addr, 32'd1);
        frame2(8'h53, 8'hff, 2);
        check("restart_addr", bus.ioctl_addr, 32'd0);
        frame2(8'h54, 8'h88, 2);
        check("restart_count", wq.size(), 32'd2);
        if (wq.size() == 2) check("restart_wr_addr", wq[1].addr, 32'd0);
        frame2(8'h53, 8'h00, 2);

        // Two 256-byte data frames at SCK = clk/4.
        wq.delete();
        frame2(8'h53, 8'hff, 2);
        for (int f = 0; f < 2; f++) begin
            frame_begin();
            spi_bits(8'h54, 8, 2);
            for (int b = 0; b < 256; b++) spi_bits(8'(b), 8, 2);
            frame_end();
        end
        check("split_count", wq.size(), 32'd512);
        errs = 0;
        foreach (wq[i])
            if (wq[i].addr != i || wq[i].data != 8'(i)) errs++;
        check("split_stream", errs, 32'd0);

        // Frame aborted after 5 bits of a data byte.
        frame_begin();
        spi_bits(8'h54, 8, 2);
        spi_bits(8'ha5, 5, 2);
        frame_end();
        check("abort_nowr", wq.size(), 32'd512);
        frame2(8'h54, 8'h3c, 2);
        check("abort_resume", wq.size(), 32'd513);
        if (wq.size() == 513) begin
            check("abort_next_addr", wq[512].addr, 32'd512);
            check("abort_next_data", wq[512].data, 32'h3c);
        end
        frame2(8'h53, 8'h00, 2);
        check("split_len", bus.ioctl_addr, 32'd513);
        check("split_dl_off", {31'b0, bus.downloading}, 32'd0);

        // Address wrap on the AW=4 instance.
        wq4.delete();
        frame2(8'h53, 8'hff, 2);
        frame_begin();
        spi_bits(8'h54, 8, 2);
        for (int b = 0; b < 18; b++) spi_bits(8'(b * 7 + 1), 8, 2);
        frame_end();
        check("wrap_count", wq4.size(), 32'd18);
        errs = 0;
        foreach (wq4[i])
            if (wq4[i].addr != (i % 16) || wq4[i].data != 8'(i * 7 + 1)) errs++;
        check("wrap_stream", errs, 32'd0);
        check("wrap_final_addr", bus4.ioctl_addr, 32'd2);
        check("nowrap_final_addr", bus.ioctl_addr, 32'd18);
        frame2(8'h53, 8'h00, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
